instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 129 ++++++++++++
 tb/tb_instruction_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: keeps at most one instruction-memory request in flight.
// It holds the fetched word for decode and follows redirects from the execute stage.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] ins_pc_plus4,
  input  logic        ins_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        kill, kill_next;
  logic [31:0] ins_q, ins_next;
  logic [31:0] ins_pc_q, ins_pc_next;
  logic        fault_q, fault_next;
  logic        bad_target;

  assign bad_target   = (redirect_pc[1:0] != 2'b00);
  assign imem_req     = (state == FETCH);
  assign imem_addr    = pc;
  assign ins_valid    = (state == HOLD);
  assign ins          = ins_q;
  assign ins_pc       = ins_pc_q;
  assign ins_pc_plus4 = ins_pc_q + 32'd4;
  assign fetch_fault  = fault_q;

  // A redirect outranks every handshake in the same cycle. A misaligned target
  // parks the stage in FAULT, and only reset can bring it back.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    kill_next   = kill;
    ins_next    = ins_q;
    ins_pc_next = ins_pc_q;
    fault_next  = fault_q;
    if (redirect && state != FAULT && bad_target) begin
      state_next = FAULT;
      fault_next = 1'b1;
      kill_next  = 1'b0;
      ins_next   = NOP_INS;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc_next = redirect_pc;
            if (imem_gnt) begin
              kill_next  = 1'b1;
              state_next = WAIT;
            end
          end else if (imem_gnt) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc_next = redirect_pc;
            if (imem_rvalid) begin
              kill_next  = 1'b0;
              state_next = FETCH;
            end else begin
              kill_next = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill_next  = 1'b0;
              state_next = FETCH;
            end else begin
              ins_next    = imem_rdata;
              ins_pc_next = pc;
              state_next  = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_next    = redirect_pc;
            ins_next   = NOP_INS;
            state_next = FETCH;
          end else if (ins_ready) begin
            pc_next    = pc + 32'd4;
            ins_next   = NOP_INS;
            state_next = FETCH;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      ins_q    <= NOP_INS;
      ins_pc_q <= RESET_PC;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      kill     <= kill_next;
      ins_q    <= ins_next;
      ins_pc_q <= ins_pc_next;
      fault_q  <= fault_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vectors drive the memory and redirect ports,
// and a scoreboard monitor checks every instruction that is presented to decode.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [31:0] ins_pc_plus4;
  logic        ins_ready;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_pc_plus4(ins_pc_plus4),
    .ins_ready(ins_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rdata,
                               input logic redir, input logic [31:0] rpc, input logic ready);
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    ins_ready   = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic expectIns(input logic [31:0] word, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e;
    e.word = word;
    e.pc   = pc;
    e.pc4  = pc4;
    exp_q.push_back(e);
  endtask

  // Monitor: a rising ins_valid pops the next expected instruction; while it stays
  // high the held word and address must not move.
  initial begin
    logic prev_valid;
    exp_t cur;
    prev_valid = 1'b0;
    cur.word = NOP; cur.pc = 32'h0; cur.pc4 = 32'h4;
    forever begin
      @(negedge clk);
      if (ins_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ins: got %h at pc %h, expected no valid instruction", ins, ins_pc);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("ins", ins, cur.word);
          checkOutput("ins_pc", ins_pc, cur.pc);
          checkOutput("ins_pc_plus4", ins_pc_plus4, cur.pc4);
        end
      end else if (ins_valid === 1'b1) begin
        checkOutput("held_ins", ins, cur.word);
        checkOutput("held_ins_pc", ins_pc, cur.pc);
      end
      prev_valid = (ins_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_ins_valid", {31'b0, ins_valid}, 32'h0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'h0);
    checkOutput("rst_ins", ins, NOP);
    checkOutput("rst_ins_pc", ins_pc, 32'h0);

    // Minimum latency fetch from address 0
    rst = 1'b0;
    checkOutput("first_req", {31'b0, imem_req}, 32'h1);
    expectIns(32'h00b00533, 32'h0, 32'h4);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("wait_req", {31'b0, imem_req}, 32'h0);
    applyStimulus(0, 1, 32'h00b00533, 0, 32'h0, 0);
    checkOutput("latency_valid", {31'b0, ins_valid}, 32'h1);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("next_addr_4", imem_addr, 32'h4);
    checkOutput("consumed_ins", ins, NOP);

    // Decode stalls for three cycles; stray gnt/rvalid must not disturb HOLD
    expectIns(32'h02000513, 32'h4, 32'h8);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h02000513, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 32'hbad0bad0, 0, 32'h0, 0);
      checkOutput("stall_req", {31'b0, imem_req}, 32'h0);
      checkOutput("stall_valid", {31'b0, ins_valid}, 32'h1);
    end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("next_addr_8", imem_addr, 32'h8);

    // Redirect in WAIT; the stale response arrives two cycles later
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1, 32'h40, 0);
    checkOutput("kill_req", {31'b0, imem_req}, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hdeadbeef, 0, 32'h0, 0);
    checkOutput("killed_valid", {31'b0, ins_valid}, 32'h0);
    checkOutput("killed_req", {31'b0, imem_req}, 32'h1);
    checkOutput("killed_addr", imem_addr, 32'h40);

    // Redirect in FETCH without gnt, then jal -20 from 0x18 taken while decode is ready
    applyStimulus(0, 0, 32'h0, 1, 32'h18, 0);
    checkOutput("fetch_redirect_addr", imem_addr, 32'h18);
    expectIns(32'hfedff0ef, 32'h18, 32'h1c);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hfedff0ef, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1, 32'h4, 1);
    checkOutput("jal_addr", imem_addr, 32'h4);
    checkOutput("jal_valid", {31'b0, ins_valid}, 32'h0);
    checkOutput("jal_ins", ins, NOP);

    // Redirect coinciding with rvalid in WAIT
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h11111111, 1, 32'h100, 0);
    checkOutput("rv_redirect_req", {31'b0, imem_req}, 32'h1);
    checkOutput("rv_redirect_addr", imem_addr, 32'h100);
    checkOutput("rv_redirect_valid", {31'b0, ins_valid}, 32'h0);

    // Redirect in FETCH together with gnt: the granted response is discarded
    applyStimulus(1, 0, 32'h0, 1, 32'h200, 0);
    checkOutput("gnt_redirect_req", {31'b0, imem_req}, 32'h0);
    checkOutput("gnt_redirect_addr", imem_addr, 32'h200);
    applyStimulus(0, 1, 32'h22222222, 0, 32'h0, 0);
    checkOutput("gnt_killed_valid", {31'b0, ins_valid}, 32'h0);
    expectIns(32'h00a00593, 32'h200, 32'h204);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00a00593, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("next_addr_204", imem_addr, 32'h204);

    // pc wraps from the top of the address space
    applyStimulus(0, 0, 32'h0, 1, 32'hfffffffc, 0);
    expectIns(32'h00100093, 32'hfffffffc, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00100093, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Reset while a killed request is outstanding, also overriding a redirect
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1, 32'h80, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 1, 32'h80, 0);
    checkOutput("rst_over_redirect", imem_addr, 32'h0);
    rst = 1'b0;
    applyStimulus(0, 1, 32'h33333333, 0, 32'h0, 0);
    checkOutput("stray_rvalid_valid", {31'b0, ins_valid}, 32'h0);
    checkOutput("stray_rvalid_req", {31'b0, imem_req}, 32'h1);
    expectIns(32'h00500293, 32'h0, 32'h4);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00500293, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);

    // Misaligned redirect target faults until reset
    applyStimulus(0, 0, 32'h0, 1, 32'h6, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fault_flag", {31'b0, fetch_fault}, 32'h1);
      checkOutput("fault_req", {31'b0, imem_req}, 32'h0);
      checkOutput("fault_valid", {31'b0, ins_valid}, 32'h0);
      applyStimulus(1, 1, 32'h44444444, 1, 32'h80, 1);
    end
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    rst = 1'b0;
    checkOutput("fault_cleared", {31'b0, fetch_fault}, 32'h0);
    checkOutput("fault_rst_addr", imem_addr, 32'h0);
    checkOutput("fault_rst_req", {31'b0, imem_req}, 32'h1);

    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("pending_expected", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
